// File: rtl/node_pkt_tx.sv
// node_pkt_tx: snapshots node state on tx_start and frames it as 5 or 6 flits (header, id, hops, q, energy[, ch_id]).
// First flit 1 cycle after an accepted request; under flit_ready backpressure the flit is held stable indefinitely.
module node_pkt_tx #(
  parameter int FLIT_W     = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [3:0]        pkt_type,
  input  logic [FLIT_W-1:0] node_id,
  input  logic [FLIT_W-1:0] hops,
  input  logic [FLIT_W-1:0] q_value,
  input  logic [FLIT_W-1:0] energy,
  input  logic [FLIT_W-1:0] ch_id,
  input  logic              role,
  input  logic              low_e,
  output logic [FLIT_W-1:0] flit_data,
  output logic              flit_valid,
  output logic              flit_last,
  input  logic              flit_ready,
  output logic              busy,
  output logic              tx_done,
  output logic              tx_drop
);

  localparam logic [3:0] PT_CH_ANN = 4'd2;
  localparam logic [3:0] PT_JOIN   = 4'd3;
  localparam logic [3:0] PT_DATA   = 4'd4;

  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        pkt_type;
    logic              role;
    logic              low_e;
    logic [FLIT_W-1:0] node_id;
    logic [FLIT_W-1:0] hops;
    logic [FLIT_W-1:0] q_value;
    logic [FLIT_W-1:0] energy;
    logic [FLIT_W-1:0] ch_id;
  } hdr_t;

  state_t             state_q, state_d;
  hdr_t               shadow_q, shadow_d;
  logic [2:0]         len_q, len_d;
  logic [2:0]         flit_cnt_q, flit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               tx_done_q, tx_done_d;
  logic               tx_drop_q, tx_drop_d;

  hdr_t               req;
  logic               type_ok;
  logic               req_legal;
  logic               req_long;
  logic               sending;
  logic               last_w;

  assign req       = {pkt_type, role, low_e, node_id, hops, q_value, energy, ch_id};
  assign type_ok   = (pkt_type >= 4'd1) && (pkt_type <= 4'd4);
  // A node may only announce itself as cluster head if it is one and has energy to spare.
  assign req_legal = type_ok && !((pkt_type == PT_CH_ANN) && (low_e || !role));
  assign req_long  = (pkt_type == PT_JOIN) || (pkt_type == PT_DATA);

  assign sending   = (state_q == S_SEND);
  assign last_w    = sending && (flit_cnt_q == (len_q - 3'd1));

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    len_d      = len_q;
    flit_cnt_d = flit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_done_d  = 1'b0;
    tx_drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (req_legal) begin
            shadow_d   = req;
            len_d      = req_long ? 3'd6 : 3'd5;
            flit_cnt_d = '0;
            state_d    = S_SEND;
          end else begin
            tx_drop_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (flit_ready) begin
          if (last_w) begin
            tx_done_d  = 1'b1;
            flit_cnt_d = '0;
            gap_cnt_d  = '0;
            state_d    = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            flit_cnt_d = flit_cnt_q + 3'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      len_q      <= '0;
      flit_cnt_q <= '0;
      gap_cnt_q  <= '0;
      tx_done_q  <= 1'b0;
      tx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      len_q      <= len_d;
      flit_cnt_q <= flit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_done_q  <= tx_done_d;
      tx_drop_q  <= tx_drop_d;
    end
  end

  // Flit payload comes only from the shadow copy, so it cannot move while stalled.
  always_comb begin
    flit_data = '0;
    if (sending) begin
      case (flit_cnt_q)
        3'd0:    flit_data = {shadow_q.pkt_type, shadow_q.role, shadow_q.low_e, 6'b0, 1'b0, len_q};
        3'd1:    flit_data = shadow_q.node_id;
        3'd2:    flit_data = shadow_q.hops;
        3'd3:    flit_data = shadow_q.q_value;
        3'd4:    flit_data = shadow_q.energy;
        3'd5:    flit_data = shadow_q.ch_id;
        default: flit_data = '0;
      endcase
    end
  end

  assign flit_valid = sending;
  assign flit_last  = last_w;
  assign busy       = (state_q != S_IDLE);
  assign tx_done    = tx_done_q;
  assign tx_drop    = tx_drop_q;

endmodule

// File: tb/tb_node_pkt_tx.sv
// Bench for node_pkt_tx: per-scenario tasks feed a flit scoreboard queue and compare as flits are accepted.
module tb_node_pkt_tx;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic [3:0]  pkt_type;
  logic [15:0] node_id, hops, q_value, energy, ch_id;
  logic        role, low_e;
  logic [15:0] flit_data;
  logic        flit_valid, flit_last, flit_ready;
  logic        busy, tx_done, tx_drop;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  node_pkt_tx #(.FLIT_W(16), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .pkt_type(pkt_type),
    .node_id(node_id), .hops(hops), .q_value(q_value), .energy(energy),
    .ch_id(ch_id), .role(role), .low_e(low_e), .flit_data(flit_data),
    .flit_valid(flit_valid), .flit_last(flit_last), .flit_ready(flit_ready),
    .busy(busy), .tx_done(tx_done), .tx_drop(tx_drop)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected flit stream for a legal request, built from the frame layout.
  task automatic push_pkt(input logic [3:0] t, input logic r, input logic le,
                          input logic [15:0] id, input logic [15:0] h, input logic [15:0] q,
                          input logic [15:0] e, input logic [15:0] ch);
    logic [3:0] len;
    len = (t == 4'd3 || t == 4'd4) ? 4'd6 : 4'd5;
    exp_q.push_back('{d: {t, r, le, 6'b0, len}, l: 1'b0});
    exp_q.push_back('{d: id, l: 1'b0});
    exp_q.push_back('{d: h,  l: 1'b0});
    exp_q.push_back('{d: q,  l: 1'b0});
    exp_q.push_back('{d: e,  l: (len == 4'd5)});
    if (len == 4'd6) exp_q.push_back('{d: ch, l: 1'b1});
  endtask

  task automatic send_req(input logic [3:0] t, input logic r, input logic le,
                          input logic [15:0] id, input logic [15:0] h, input logic [15:0] q,
                          input logic [15:0] e, input logic [15:0] ch, input bit legal);
    pkt_type = t; role = r; low_e = le;
    node_id = id; hops = h; q_value = q; energy = e; ch_id = ch;
    tx_start = 1'b1;
    if (legal) push_pkt(t, r, le, id, h, q, e, ch);
    cyc();
    tx_start = 1'b0;
    if (legal) begin
      total++; if (flit_valid !== 1'b1) begin bad++; $display("FAIL start_latency valid=%b want 1", flit_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy busy=%b want 1", busy); end
      total++; if (tx_drop !== 1'b0) begin bad++; $display("FAIL start_nodrop drop=%b want 0", tx_drop); end
    end else begin
      total++; if (tx_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse type=%h drop=%b want 1", t, tx_drop); end
      total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL drop_novalid valid=%b want 0", flit_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_notbusy busy=%b want 0", busy); end
    end
  endtask

  // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic drain(input int mode, input int poke_at, output int cycles);
    logic [15:0] held_d;
    logic        held_l;
    bit          stalled;
    exp_t        e;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    cycles  = 0;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
      flit_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      tx_start   = (i == poke_at);
      total++; if (flit_valid !== 1'b1) begin bad++; $display("FAIL valid_held cyc=%0d valid=%b want 1", i, flit_valid); end
      total++; if (tx_done !== 1'b0 || tx_drop !== 1'b0) begin bad++; $display("FAIL quiet_pulses cyc=%0d done=%b drop=%b want 0 0", i, tx_done, tx_drop); end
      if (stalled) begin
        total++;
        if (flit_data !== held_d || flit_last !== held_l) begin
          bad++; $display("FAIL stall_stable data=%h last=%b want %h %b", flit_data, flit_last, held_d, held_l);
        end
      end
      if (flit_ready) begin
        e = exp_q.pop_front();
        total++; if (flit_data !== e.d) begin bad++; $display("FAIL flit_data got=%h want=%h", flit_data, e.d); end
        total++; if (flit_last !== e.l) begin bad++; $display("FAIL flit_last got=%b want=%b data=%h", flit_last, e.l, e.d); end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d  = flit_data;
        held_l  = flit_last;
      end
      cyc();
      cycles++;
    end
    tx_start   = 1'b0;
    flit_ready = 1'b1;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_timeout left=%0d want 0", exp_q.size());
      exp_q.delete();
    end
    total++; if (tx_done !== 1'b1) begin bad++; $display("FAIL tx_done_pulse done=%b want 1", tx_done); end
    total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL valid_after_last valid=%b want 0", flit_valid); end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_timeout busy=%b want 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_start = 1'b0; flit_ready = 1'b0;
    pkt_type = '0; role = 1'b0; low_e = 1'b0;
    node_id = '0; hops = '0; q_value = '0; energy = '0; ch_id = '0;
    repeat (3) cyc();
    total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want 0", flit_valid); end
    total++; if (flit_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h want 0", flit_data); end
    total++; if (flit_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want 0", flit_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want 0", busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want 0", tx_done); end
    total++; if (tx_drop !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b want 0", tx_drop); end
    rst = 1'b0;
    flit_ready = 1'b1;
    cyc();
  endtask

  task automatic test_hello();
    int n;
    send_req(4'd1, 1'b0, 1'b0, 16'h0007, 16'h0003, 16'h1234, 16'h8000, 16'h0000, 1'b1);
    total++;
    if (exp_q[0].d !== 16'h1005) begin bad++; $display("FAIL hello_hdr_model got=%h want 1005", exp_q[0].d); end
    drain(0, -1, n);
    total++; if (n != 5) begin bad++; $display("FAIL hello_consecutive cycles=%0d want 5", n); end
    cyc();
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL done_one_cycle done=%b want 0", tx_done); end
    wait_idle();
  endtask

  task automatic test_data_stall();
    int n;
    send_req(4'd4, 1'b0, 1'b0, 16'h0011, 16'h0002, 16'h0F0F, 16'h7777, 16'h0002, 1'b1);
    total++;
    if (exp_q[0].d !== 16'h4006 || exp_q[5].d !== 16'h0002) begin
      bad++; $display("FAIL data_model f0=%h f5=%h want 4006 0002", exp_q[0].d, exp_q[5].d);
    end
    drain(1, -1, n);
    wait_idle();
  endtask

  task automatic test_illegal();
    send_req(4'd2, 1'b1, 1'b1, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0);
    cyc();
    total++; if (tx_drop !== 1'b0 || flit_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL drop_single drop=%b valid=%b busy=%b want 0 0 0", tx_drop, flit_valid, busy);
    end
    send_req(4'd2, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0);
    cyc();
    send_req(4'hF, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0);
    cyc();
    send_req(4'h0, 1'b1, 1'b0, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0);
    cyc();
    total++; if (flit_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL drop_quiet valid=%b busy=%b want 0 0", flit_valid, busy);
    end
  endtask

  task automatic test_ch_announce();
    int n;
    send_req(4'd2, 1'b1, 1'b0, 16'h00C1, 16'h0004, 16'h4321, 16'h6000, 16'h00C1, 1'b1);
    drain(0, -1, n);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n, cnt;
    send_req(4'd1, 1'b0, 1'b0, 16'h0101, 16'h0005, 16'h0A0A, 16'h5555, 16'h0000, 1'b1);
    drain(0, 2, n);
    total++; if (n != 5) begin bad++; $display("FAIL busy_start_ignored cycles=%0d want 5", n); end
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL gap_valid cnt=%0d valid=%b want 0", cnt, flit_valid); end
      tx_start = (cnt == 1);
      cyc();
      cnt++;
    end
    tx_start = 1'b0;
    total++; if (cnt != G) begin bad++; $display("FAIL gap_len got=%0d want %0d", cnt, G); end
    total++; if (tx_drop !== 1'b0 || flit_valid !== 1'b0) begin
      bad++; $display("FAIL gap_start_ignored drop=%b valid=%b want 0 0", tx_drop, flit_valid);
    end
    send_req(4'd3, 1'b0, 1'b1, 16'h0102, 16'h0006, 16'h0B0B, 16'h0100, 16'h0009, 1'b1);
    drain(0, -1, n);
    wait_idle();
  endtask

  task automatic test_reset_mid_packet();
    exp_t e;
    int   n;
    send_req(4'd1, 1'b0, 1'b0, 16'h0033, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      flit_ready = 1'b1;
      e = exp_q.pop_front();
      total++; if (flit_data !== e.d) begin bad++; $display("FAIL pre_rst_data got=%h want=%h", flit_data, e.d); end
      cyc();
    end
    rst = 1'b1;
    cyc();
    exp_q.delete();
    total++; if (flit_valid !== 1'b0 || busy !== 1'b0 || flit_last !== 1'b0) begin
      bad++; $display("FAIL abort_outputs valid=%b busy=%b last=%b want 0 0 0", flit_valid, busy, flit_last);
    end
    total++; if (flit_data !== 16'h0 || tx_done !== 1'b0 || tx_drop !== 1'b0) begin
      bad++; $display("FAIL abort_data data=%h done=%b drop=%b want 0 0 0", flit_data, tx_done, tx_drop);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++; if (tx_done !== 1'b0 || flit_valid !== 1'b0) begin
        bad++; $display("FAIL abort_no_done done=%b valid=%b want 0 0", tx_done, flit_valid);
      end
    end
    send_req(4'd1, 1'b0, 1'b0, 16'h0007, 16'h0003, 16'h1234, 16'h8000, 16'h0000, 1'b1);
    drain(0, -1, n);
    wait_idle();
  endtask

  task automatic test_capture();
    int n;
    send_req(4'd4, 1'b0, 1'b0, 16'h00AA, 16'h0002, 16'h0C0C, 16'h4444, 16'h0005, 1'b1);
    node_id  = 16'hBEEF;
    hops     = 16'hFFFF;
    pkt_type = 4'd1;
    drain(0, -1, n);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_hello();
    test_data_stall();
    test_illegal();
    test_ch_announce();
    test_back_to_back();
    test_reset_mid_packet();
    test_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
